aes_gcm_ctr_block_gen: RTL and testbench

AES_GCM_CTR_BLOCK_GEN -- requirements
Module: aes_gcm_ctr_block_gen

---
 rtl/aes_gcm_ctr_block_gen.sv | 144 ++++++++++++++
 tb/tb_aes_gcm_ctr_block_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_gcm_ctr_block_gen.sv
// AES-GCM counter-block generator: pairs each AAD/text block with its CTR block
// and queues them in a 2-entry FIFO whose head is held in output registers.
module aes_gcm_ctr_block_gen (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] i_counter,
  input  logic [0:2]   i_phase,
  input  logic [0:95]  i_iv,
  input  logic [0:127] i_aad,
  input  logic [0:127] i_plain_text,
  input  logic         i_new_instance,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [0:127] o_ctr_block,
  output logic [0:127] o_data_block,
  output logic         o_is_aad,
  output logic         o_first,
  output logic         o_last,
  output logic [0:127] o_j0,
  output logic         o_overflow
);

  typedef struct packed {
    logic [0:127] ctr;
    logic [0:127] data;
    logic         is_aad;
    logic         first;
    logic         last;
  } entry_t;

  // Text index is tracked locally, so the stage-1 counter is not needed.
  logic unused_counter;
  assign unused_counter = ^i_counter;

  entry_t       head_q, head_d, tail_q, tail_d, new_e;
  logic [1:0]   count_q, count_d;
  logic         valid_q, valid_d;
  logic [31:0]  t_q, t_d, t_eff;
  logic [0:127] j0_q, j0_d;
  logic         ovf_q, ovf_d;
  logic         push, is_text, pop, drop;

  always_comb begin
    t_eff   = i_new_instance ? '0 : t_q;
    push    = 1'b1;
    is_text = 1'b0;
    new_e   = '0;
    unique case (i_phase)
      3'b100: push = 1'b0;
      3'b010: begin
        new_e.data   = i_aad;
        new_e.is_aad = 1'b1;
      end
      default: begin
        is_text     = 1'b1;
        new_e.data  = i_plain_text;
        new_e.ctr   = {i_iv, t_eff + 32'd2};
        new_e.first = (i_phase == 3'b000) || (i_phase == 3'b111);
        new_e.last  = (i_phase == 3'b011) || (i_phase == 3'b111);
      end
    endcase
  end

  assign pop  = valid_q && i_ready;
  assign drop = push && (count_q == 2'd2) && !pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = new_e;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_e;
        end else if (pop) begin
          // Clearing the head keeps the flags low while the queue is empty.
          head_d  = '0;
          count_d = 2'd0;
        end else if (push) begin
          tail_d  = new_e;
          count_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = new_e;
          else      count_d = 2'd1;
        end
      end
    endcase
    valid_d = (count_d != 2'd0);
  end

  always_comb begin
    t_d   = t_q;
    j0_d  = j0_q;
    ovf_d = ovf_q;
    if (i_new_instance) begin
      t_d   = '0;
      j0_d  = {i_iv, 32'h0000_0001};
      ovf_d = 1'b0;
    end
    // The index advances even when the entry itself is dropped.
    if (push && is_text) t_d = t_eff + 32'd1;
    if (drop)            ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      t_q     <= '0;
      j0_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      t_q     <= t_d;
      j0_q    <= j0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_ctr_block  = head_q.ctr;
  assign o_data_block = head_q.data;
  assign o_is_aad     = head_q.is_aad;
  assign o_first      = head_q.first;
  assign o_last       = head_q.last;
  assign o_j0         = j0_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_aes_gcm_ctr_block_gen.sv
// Directed bench for aes_gcm_ctr_block_gen: expected values are hand-computed
// from the IVs and the text index sequence of each scenario.
module tb_aes_gcm_ctr_block_gen;

  logic         clk;
  logic         rst;
  logic [0:127] i_counter;
  logic [0:2]   i_phase;
  logic [0:95]  i_iv;
  logic [0:127] i_aad;
  logic [0:127] i_plain_text;
  logic         i_new_instance;
  logic         i_ready;
  logic         o_valid;
  logic [0:127] o_ctr_block;
  logic [0:127] o_data_block;
  logic         o_is_aad;
  logic         o_first;
  logic         o_last;
  logic [0:127] o_j0;
  logic         o_overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [0:95]  IV1 = 96'hCAFEBABE_DEADBEEF_00000000;
  localparam logic [0:95]  IV2 = 96'h00112233_44556677_8899AABB;
  localparam logic [0:95]  IV3 = 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [0:127] A1  = 128'hA1A1A1A1_00000000_11111111_A1A1A1A1;
  localparam logic [0:127] P1  = 128'h01010101_02020202_03030303_04040404;
  localparam logic [0:127] P2  = 128'h10101010_20202020_30303030_40404040;
  localparam logic [0:127] P3  = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5;
  localparam logic [0:127] P4  = 128'hDEADBEEF_FEEDFACE_01234567_89ABCDEF;

  aes_gcm_ctr_block_gen dut (
    .clk            (clk),
    .rst            (rst),
    .i_counter      (i_counter),
    .i_phase        (i_phase),
    .i_iv           (i_iv),
    .i_aad          (i_aad),
    .i_plain_text   (i_plain_text),
    .i_new_instance (i_new_instance),
    .i_ready        (i_ready),
    .o_valid        (o_valid),
    .o_ctr_block    (o_ctr_block),
    .o_data_block   (o_data_block),
    .o_is_aad       (o_is_aad),
    .o_first        (o_first),
    .o_last         (o_last),
    .o_j0           (o_j0),
    .o_overflow     (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input logic [0:127] ctr, input logic [0:127] data,
                           input logic aad, input logic first, input logic last);
    chk1  ({tag, ".valid"}, o_valid, 1'b1);
    chk128({tag, ".ctr"},   o_ctr_block, ctr);
    chk128({tag, ".data"},  o_data_block, data);
    chk1  ({tag, ".aad"},   o_is_aad, aad);
    chk1  ({tag, ".first"}, o_first, first);
    chk1  ({tag, ".last"},  o_last, last);
  endtask

  task automatic chk_empty(input string tag);
    chk1({tag, ".valid"}, o_valid, 1'b0);
    chk1({tag, ".aad"},   o_is_aad, 1'b0);
    chk1({tag, ".first"}, o_first, 1'b0);
    chk1({tag, ".last"},  o_last, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_counter = 128'h0000_0000_0000_0000_0000_0000_DEAD_0007;
    i_phase = 3'b100;
    i_iv = '0;
    i_aad = '0;
    i_plain_text = '0;
    i_new_instance = 1'b0;
    i_ready = 1'b0;
    step();
    step();
    chk_empty("reset");
    chk128("reset.ctr", o_ctr_block, '0);
    chk128("reset.data", o_data_block, '0);
    chk128("reset.j0", o_j0, '0);
    chk1("reset.ovf", o_overflow, 1'b0);
    rst = 1'b0;
    step();
    chk_empty("idle");

    // Scenario 1: AAD then first/middle/last text
    i_iv = IV1; i_new_instance = 1'b1; i_ready = 1'b1; i_phase = 3'b100;
    step();
    i_new_instance = 1'b0;
    chk128("s1.j0", o_j0, {IV1, 32'h0000_0001});
    chk_empty("s1.noinst");
    i_phase = 3'b010; i_aad = A1;
    step();
    chk_entry("s1.e1", '0, A1, 1'b1, 1'b0, 1'b0);
    i_phase = 3'b000; i_plain_text = P1;
    step();
    chk_entry("s1.e2", {IV1, 32'd2}, P1, 1'b0, 1'b1, 1'b0);
    i_phase = 3'b001; i_plain_text = P2;
    step();
    chk_entry("s1.e3", {IV1, 32'd3}, P2, 1'b0, 1'b0, 1'b0);
    i_phase = 3'b011; i_plain_text = P3;
    step();
    chk_entry("s1.e4", {IV1, 32'd4}, P3, 1'b0, 1'b0, 1'b1);
    i_phase = 3'b100;
    step();
    chk_empty("s1.drained");

    // Scenario 2: single first-and-last block with new instance same cycle
    i_iv = IV2; i_new_instance = 1'b1; i_phase = 3'b111; i_plain_text = P4;
    step();
    i_new_instance = 1'b0; i_phase = 3'b100;
    chk_entry("s2.e1", {IV2, 32'd2}, P4, 1'b0, 1'b1, 1'b1);
    chk128("s2.j0", o_j0, {IV2, 32'h0000_0001});
    step();
    chk_empty("s2.drained");

    // Scenario 3: stall, third push dropped
    i_ready = 1'b0; i_new_instance = 1'b1; i_phase = 3'b000; i_plain_text = P1;
    step();
    i_new_instance = 1'b0;
    chk_entry("s3.h1", {IV2, 32'd2}, P1, 1'b0, 1'b1, 1'b0);
    chk1("s3.ovf0", o_overflow, 1'b0);
    i_phase = 3'b001; i_plain_text = P2;
    step();
    chk_entry("s3.hold", {IV2, 32'd2}, P1, 1'b0, 1'b1, 1'b0);
    i_phase = 3'b011; i_plain_text = P3;
    step();
    chk_entry("s3.hold2", {IV2, 32'd2}, P1, 1'b0, 1'b1, 1'b0);
    chk1("s3.ovf1", o_overflow, 1'b1);
    i_phase = 3'b100; i_ready = 1'b1;
    step();
    chk_entry("s3.h2", {IV2, 32'd3}, P2, 1'b0, 1'b0, 1'b0);
    chk1("s3.ovf_sticky", o_overflow, 1'b1);
    step();
    chk_empty("s3.drained");
    i_new_instance = 1'b1;
    step();
    i_new_instance = 1'b0;
    chk1("s3.ovf_clr", o_overflow, 1'b0);

    // Scenario 4: counter field wraps without touching the IV
    i_iv = IV3; i_new_instance = 1'b1;
    step();
    i_new_instance = 1'b0;
    force dut.t_q = 32'hFFFF_FFFE;
    #1;
    release dut.t_q;
    i_phase = 3'b001; i_plain_text = P1;
    step();
    chk_entry("s4.wrap0", {IV3, 32'h0000_0000}, P1, 1'b0, 1'b0, 1'b0);
    i_plain_text = P2;
    step();
    chk_entry("s4.wrap1", {IV3, 32'h0000_0001}, P2, 1'b0, 1'b0, 1'b0);
    i_phase = 3'b100;
    step();
    chk_empty("s4.drained");

    // Scenario 5: push and pop on a full FIFO
    i_iv = IV1; i_ready = 1'b0; i_new_instance = 1'b1; i_phase = 3'b000; i_plain_text = P1;
    step();
    i_new_instance = 1'b0; i_phase = 3'b001; i_plain_text = P2;
    step();
    chk_entry("s5.full", {IV1, 32'd2}, P1, 1'b0, 1'b1, 1'b0);
    i_ready = 1'b1; i_plain_text = P3;
    step();
    chk_entry("s5.e2", {IV1, 32'd3}, P2, 1'b0, 1'b0, 1'b0);
    chk1("s5.noovf", o_overflow, 1'b0);
    i_phase = 3'b011; i_plain_text = P4;
    step();
    chk_entry("s5.e3", {IV1, 32'd4}, P3, 1'b0, 1'b0, 1'b0);
    i_phase = 3'b100;
    step();
    chk_entry("s5.e4", {IV1, 32'd5}, P4, 1'b0, 1'b0, 1'b1);
    step();
    chk_empty("s5.drained");
    chk1("s5.noovf2", o_overflow, 1'b0);

    // Scenario 6: async reset with two entries queued
    i_ready = 1'b0; i_phase = 3'b000; i_plain_text = P1;
    step();
    i_phase = 3'b001; i_plain_text = P2;
    step();
    chk_entry("s6.pre", {IV1, 32'd6}, P1, 1'b0, 1'b1, 1'b0);
    i_phase = 3'b100;
    #2;
    rst = 1'b1;
    #1;
    chk_empty("s6.async");
    chk128("s6.j0", o_j0, '0);
    #1;
    rst = 1'b0;
    step();
    chk_empty("s6.idle1");
    step();
    chk_empty("s6.idle2");
    i_ready = 1'b1; i_phase = 3'b000; i_plain_text = P3;
    step();
    i_phase = 3'b100;
    chk_entry("s6.fresh", {IV1, 32'd2}, P3, 1'b0, 1'b1, 1'b0);
    step();
    chk_empty("s6.drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
